usb_hid_supervisor: RTL and testbench

Power/reset sequencer and health monitor for one usb_hid_host instance.
- Drives VBUS enable and the host core's usbrst_n.
- Waits for enumeration (typ != 0), then passes reports through.
- Recovers from conerr or enumeration timeout by power-cycling with exponential backoff.
- Latches a fault after repeated failures. Sits between the top level (enable/retry/status) and usb_hid_host.

---
 rtl/usb_hid_supervisor_if.sv | 25 ++
 rtl/usb_hid_supervisor.sv | 213 +++++++++++++++++++++
 tb/tb_usb_hid_supervisor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_hid_supervisor_if.sv
// Host-side bundle between the supervisor and one usb_hid_host core:
// device status coming up, VBUS and core reset going down.
interface usb_hid_supervisor_if;
    logic [1:0] host_typ;
    logic       host_report;
    logic       host_conerr;
    logic       vbus_en;
    logic       host_rst_n;

    modport master (
        input  host_typ,
        input  host_report,
        input  host_conerr,
        output vbus_en,
        output host_rst_n
    );

    modport slave (
        output host_typ,
        output host_report,
        output host_conerr,
        input  vbus_en,
        input  host_rst_n
    );
endinterface

// File: rtl/usb_hid_supervisor.sv
// Power/reset sequencer and health monitor for one usb_hid_host core:
// power-up, enumeration wait, report pass-through, backoff recovery and fault latch.
module usb_hid_supervisor #(
    parameter int unsigned SETTLE_CYC       = 600000,
    parameter int unsigned RST_CYC          = 1200,
    parameter int unsigned ENUM_TIMEOUT_CYC = 24000000,
    parameter int unsigned PWR_OFF_CYC      = 1200000,
    parameter int unsigned MAX_RETRY        = 5
) (
    input  logic                        usbclk,
    input  logic                        usbrst_n,
    input  logic                        enable,
    input  logic                        retry,
    usb_hid_supervisor_if.master        host,
    output logic [2:0]                  state,
    output logic [1:0]                  dev_typ,
    output logic                        dev_ready,
    output logic                        rpt_out,
    output logic [2:0]                  retry_cnt,
    output logic                        fault,
    output logic [15:0]                 report_cnt
);

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_HOST_RST = 3'd2,
        ST_ENUM     = 3'd3,
        ST_RUN      = 3'd4,
        ST_BACKOFF  = 3'd5,
        ST_FAULT    = 3'd6
    } state_t;

    // Timer values on the edge where each wait expires ("reaches N" == N-1).
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] RST_LAST    = 32'(RST_CYC - 1);
    localparam logic [31:0] ENUM_LAST   = 32'(ENUM_TIMEOUT_CYC - 1);
    localparam logic [31:0] PWR_OFF_W   = 32'(PWR_OFF_CYC);
    localparam logic [3:0]  MAX_RETRY_4 = 4'(MAX_RETRY);
    localparam logic [2:0]  MAX_RETRY_3 = 3'(MAX_RETRY);

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] timer_r;
    logic [2:0]  retry_cnt_r;
    logic [2:0]  next_retry_s;
    logic        fail_s;
    logic [1:0]  shift_s;
    logic [31:0] backoff_last_s;
    logic        vbus_en_r;
    logic        host_rst_n_r;
    logic [1:0]  dev_typ_r;
    logic        dev_ready_r;
    logic        rpt_out_r;
    logic        rpt_s;
    logic        fault_r;
    logic [15:0] report_cnt_r;

    // Backoff length grows with the already-incremented failure count, capped at 8x.
    always_comb begin
        shift_s = 2'd0;
        if (retry_cnt_r >= 3'd3) begin
            shift_s = 2'd3;
        end else begin
            shift_s = retry_cnt_r[1:0];
        end
        backoff_last_s = (PWR_OFF_W << shift_s) - 32'd1;
    end

    // Next-state and retry-count decision, enable dominating everything.
    always_comb begin
        next_state_s = state_r;
        next_retry_s = retry_cnt_r;
        fail_s       = 1'b0;
        if (!enable) begin
            next_state_s = ST_OFF;
            next_retry_s = 3'd0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    next_state_s = ST_PWR_UP;
                end
                ST_PWR_UP: begin
                    if (timer_r == SETTLE_LAST) begin
                        next_state_s = ST_HOST_RST;
                    end else begin
                        next_state_s = ST_PWR_UP;
                    end
                end
                ST_HOST_RST: begin
                    if (timer_r == RST_LAST) begin
                        next_state_s = ST_ENUM;
                    end else begin
                        next_state_s = ST_HOST_RST;
                    end
                end
                ST_ENUM: begin
                    if (host.host_conerr) begin
                        fail_s = 1'b1;
                    end else if (host.host_typ != 2'd0) begin
                        next_state_s = ST_RUN;
                        next_retry_s = 3'd0;
                    end else if (timer_r == ENUM_LAST) begin
                        fail_s = 1'b1;
                    end else begin
                        next_state_s = ST_ENUM;
                    end
                end
                ST_RUN: begin
                    if (host.host_conerr) begin
                        fail_s = 1'b1;
                    end else if (host.host_typ == 2'd0) begin
                        next_state_s = ST_ENUM;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_BACKOFF: begin
                    if (timer_r == backoff_last_s) begin
                        next_state_s = ST_PWR_UP;
                    end else begin
                        next_state_s = ST_BACKOFF;
                    end
                end
                ST_FAULT: begin
                    if (retry) begin
                        next_state_s = ST_PWR_UP;
                        next_retry_s = 3'd0;
                    end else begin
                        next_state_s = ST_FAULT;
                    end
                end
                default: begin
                    next_state_s = ST_OFF;
                    next_retry_s = 3'd0;
                end
            endcase

            if (fail_s) begin
                if (({1'b0, retry_cnt_r} + 4'd1) >= MAX_RETRY_4) begin
                    next_state_s = ST_FAULT;
                    next_retry_s = MAX_RETRY_3;
                end else begin
                    next_state_s = ST_BACKOFF;
                    next_retry_s = retry_cnt_r + 3'd1;
                end
            end else begin
                next_retry_s = next_retry_s;
            end
        end
    end

    // A report is forwarded only if RUN holds across the sampling edge.
    always_comb begin
        rpt_s = 1'b0;
        if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
            rpt_s = host.host_report;
        end else begin
            rpt_s = 1'b0;
        end
    end

    // State, timer and all registered outputs, decoded from the next state.
    always_ff @(posedge usbclk) begin
        if (!usbrst_n) begin
            state_r      <= ST_OFF;
            timer_r      <= 32'd0;
            retry_cnt_r  <= 3'd0;
            vbus_en_r    <= 1'b0;
            host_rst_n_r <= 1'b0;
            dev_typ_r    <= 2'd0;
            dev_ready_r  <= 1'b0;
            rpt_out_r    <= 1'b0;
            fault_r      <= 1'b0;
            report_cnt_r <= 16'd0;
        end else begin
            state_r     <= next_state_s;
            retry_cnt_r <= next_retry_s;
            if (next_state_s != state_r) begin
                timer_r <= 32'd0;
            end else begin
                timer_r <= timer_r + 32'd1;
            end
            vbus_en_r    <= (next_state_s == ST_PWR_UP) || (next_state_s == ST_HOST_RST) ||
                            (next_state_s == ST_ENUM)   || (next_state_s == ST_RUN);
            host_rst_n_r <= (next_state_s == ST_ENUM) || (next_state_s == ST_RUN);
            dev_ready_r  <= (next_state_s == ST_RUN);
            if (next_state_s == ST_RUN) begin
                dev_typ_r <= host.host_typ;
            end else begin
                dev_typ_r <= 2'd0;
            end
            fault_r   <= (next_state_s == ST_FAULT);
            rpt_out_r <= rpt_s;
            if (rpt_s) begin
                report_cnt_r <= report_cnt_r + 16'd1;
            end else begin
                report_cnt_r <= report_cnt_r;
            end
        end
    end

    assign state           = state_r;
    assign retry_cnt       = retry_cnt_r;
    assign host.vbus_en    = vbus_en_r;
    assign host.host_rst_n = host_rst_n_r;
    assign dev_typ         = dev_typ_r;
    assign dev_ready       = dev_ready_r;
    assign rpt_out         = rpt_out_r;
    assign fault           = fault_r;
    assign report_cnt      = report_cnt_r;

endmodule

// File: tb/tb_usb_hid_supervisor.sv
// Directed bench for usb_hid_supervisor with shortened timing parameters
// (SETTLE=8, RST=4, ENUM_TIMEOUT=32, PWR_OFF=16, MAX_RETRY=2).
module tb_usb_hid_supervisor;

    logic        usbclk;
    logic        usbrst_n;
    logic        enable;
    logic        retry;
    logic [2:0]  state;
    logic [1:0]  dev_typ;
    logic        dev_ready;
    logic        rpt_out;
    logic [2:0]  retry_cnt;
    logic        fault;
    logic [15:0] report_cnt;

    int checks   = 0;
    int failures = 0;

    usb_hid_supervisor_if hif ();

    usb_hid_supervisor #(
        .SETTLE_CYC       (8),
        .RST_CYC          (4),
        .ENUM_TIMEOUT_CYC (32),
        .PWR_OFF_CYC      (16),
        .MAX_RETRY        (2)
    ) dut (
        .usbclk     (usbclk),
        .usbrst_n   (usbrst_n),
        .enable     (enable),
        .retry      (retry),
        .host       (hif.master),
        .state      (state),
        .dev_typ    (dev_typ),
        .dev_ready  (dev_ready),
        .rpt_out    (rpt_out),
        .retry_cnt  (retry_cnt),
        .fault      (fault),
        .report_cnt (report_cnt)
    );

    initial usbclk = 1'b0;
    always #5 usbclk = ~usbclk;

    task automatic step(input int n);
        repeat (n) @(posedge usbclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic vb,
                              input logic hr, input logic [2:0] rc, input logic ft);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_vbus"}, 32'(hif.vbus_en), 32'(vb));
        check({tag, "_hrst"}, 32'(hif.host_rst_n), 32'(hr));
        check({tag, "_retry"}, 32'(retry_cnt), 32'(rc));
        check({tag, "_fault"}, 32'(fault), 32'(ft));
    endtask

    initial begin
        usbrst_n = 1'b0;
        enable = 1'b0;
        retry = 1'b0;
        hif.host_typ = 2'd0;
        hif.host_report = 1'b0;
        hif.host_conerr = 1'b1;
        step(2);
        check_outs("reset", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("reset_cnt", 32'(report_cnt), 32'd0);

        // Power-up sequence: 8 cycles PWR_UP, 4 cycles HOST_RST, then ENUM.
        usbrst_n = 1'b1;
        enable = 1'b1;
        step(1);
        check_outs("pwrup", 3'd1, 1'b1, 1'b0, 3'd0, 1'b0);
        step(7);
        check("pwrup_end", 32'(state), 32'd1);
        step(1);
        check_outs("hrst", 3'd2, 1'b1, 1'b0, 3'd0, 1'b0);
        step(3);
        check("hrst_end", 32'(state), 32'd2);
        step(1);
        check_outs("enum", 3'd3, 1'b1, 1'b1, 3'd0, 1'b0);
        hif.host_conerr = 1'b0;
        step(4);
        check("enum_wait", 32'(state), 32'd3);
        hif.host_typ = 2'd1;
        step(1);
        check_outs("run", 3'd4, 1'b1, 1'b1, 3'd0, 1'b0);
        check("run_typ", 32'(dev_typ), 32'd1);
        check("run_ready", 32'(dev_ready), 32'd1);

        // Three report pulses, each seen one cycle later.
        for (int i = 0; i < 3; i++) begin
            hif.host_report = 1'b1;
            step(1);
            hif.host_report = 1'b0;
            check("rpt_hi", 32'(rpt_out), 32'd1);
            check("rpt_cnt", 32'(report_cnt), 32'(i + 1));
            step(1);
            check("rpt_lo", 32'(rpt_out), 32'd0);
        end

        // Report together with conerr: dropped, first failure -> BACKOFF.
        hif.host_report = 1'b1;
        hif.host_conerr = 1'b1;
        step(1);
        hif.host_report = 1'b0;
        hif.host_conerr = 1'b0;
        check_outs("conerr", 3'd5, 1'b0, 1'b0, 3'd1, 1'b0);
        check("conerr_rpt", 32'(rpt_out), 32'd0);
        check("conerr_cnt", 32'(report_cnt), 32'd3);
        check("conerr_ready", 32'(dev_ready), 32'd0);
        check("conerr_typ", 32'(dev_typ), 32'd0);

        // enable=0 mid-BACKOFF clears retry count.
        hif.host_typ = 2'd0;
        step(10);
        check("bo_mid", 32'(state), 32'd5);
        enable = 1'b0;
        step(1);
        check_outs("dis", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        enable = 1'b1;
        step(1);
        check("reen", 32'(state), 32'd1);
        step(8);
        check("reen_hrst", 32'(state), 32'd2);
        step(4);
        check("reen_enum", 32'(state), 32'd3);

        // Enumeration timeout after 32 cycles, backoff 16<<1 = 32 cycles.
        step(31);
        check("to1_pre", 32'(state), 32'd3);
        step(1);
        check_outs("to1", 3'd5, 1'b0, 1'b0, 3'd1, 1'b0);
        step(31);
        check("bo1_pre", 32'(state), 32'd5);
        step(1);
        check_outs("bo1_end", 3'd1, 1'b1, 1'b0, 3'd1, 1'b0);
        step(8);
        check("hrst2", 32'(state), 32'd2);

        // conerr while host reset is low is ignored.
        hif.host_conerr = 1'b1;
        step(3);
        check("hrst_conerr", 32'(state), 32'd2);
        step(1);
        hif.host_conerr = 1'b0;
        check("enum2", 32'(state), 32'd3);
        step(31);
        check("to2_pre", 32'(state), 32'd3);
        step(1);
        check_outs("fault", 3'd6, 1'b0, 1'b0, 3'd2, 1'b1);
        step(5);
        check("fault_hold", 32'(state), 32'd6);
        retry = 1'b1;
        step(1);
        retry = 1'b0;
        check_outs("retry", 3'd1, 1'b1, 1'b0, 3'd0, 1'b0);

        // Back to RUN with typ 2; retry pulse in RUN has no effect.
        step(8);
        step(4);
        check("enum3", 32'(state), 32'd3);
        step(2);
        hif.host_typ = 2'd2;
        step(1);
        check("run2_typ", 32'(dev_typ), 32'd2);
        retry = 1'b1;
        step(1);
        retry = 1'b0;
        check("run_retry", 32'(state), 32'd4);

        // Unplug: RUN -> ENUM with VBUS kept, re-enumerate as typ 3.
        hif.host_typ = 2'd0;
        step(1);
        check_outs("unplug", 3'd3, 1'b1, 1'b1, 3'd0, 1'b0);
        check("unplug_typ", 32'(dev_typ), 32'd0);
        check("unplug_ready", 32'(dev_ready), 32'd0);
        step(9);
        hif.host_typ = 2'd3;
        step(1);
        check_outs("replug", 3'd4, 1'b1, 1'b1, 3'd0, 1'b0);
        check("replug_typ", 32'(dev_typ), 32'd3);
        hif.host_typ = 2'd1;
        step(1);
        check("follow_typ", 32'(dev_typ), 32'd1);
        check("cnt_kept", 32'(report_cnt), 32'd3);

        // Report on the RUN-exit (unplug) cycle is dropped.
        hif.host_typ = 2'd0;
        hif.host_report = 1'b1;
        step(1);
        hif.host_report = 1'b0;
        check("exit_rpt", 32'(rpt_out), 32'd0);
        check("exit_cnt", 32'(report_cnt), 32'd3);
        hif.host_typ = 2'd2;
        step(1);
        check("run3", 32'(state), 32'd4);

        // Synchronous reset mid-RUN.
        usbrst_n = 1'b0;
        hif.host_report = 1'b1;
        step(1);
        check_outs("rst_run", 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("rst_typ", 32'(dev_typ), 32'd0);
        check("rst_ready", 32'(dev_ready), 32'd0);
        check("rst_rpt", 32'(rpt_out), 32'd0);
        check("rst_cnt", 32'(report_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
